// File: rtl/add_32bit_unsigned_seq.sv
// ---------------------------------------------------------------------------
// add_32bit_unsigned_seq
//
// Digit-serial unsigned adder. Accepts one operand pair over a valid/ready
// input handshake, adds DIGIT_W bits per cycle (least-significant slice
// first) with a carry chained between slices, and then presents
// {carry, result} over a valid/ready output handshake.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. in_ready is high only in IDLE and out_valid
// is high only in DONE, so acceptance never overlaps computation or output.
//
// Parameters:
//   WIDTH    operand/result width in bits
//   DIGIT_W  bits added per cycle; must divide WIDTH exactly (1..WIDTH)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   producer has A/B available
//   in_ready   block can accept an operand pair (registered)
//   A, B       unsigned operands, sampled on the input handshake
//   out_valid  result/carry valid (registered)
//   out_ready  consumer accepts the result
//   result     (A + B) mod 2^WIDTH (registered)
//   carry      bit WIDTH of A + B (registered)
// ---------------------------------------------------------------------------
module add_32bit_unsigned_seq #(
  parameter int WIDTH   = 32,
  parameter int DIGIT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam int N     = WIDTH / DIGIT_W;
  // A one-step configuration still needs a one-bit counter.
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
  // Mask covering one digit in the least-significant position.
  localparam logic [WIDTH-1:0] DMASK = WIDTH'({DIGIT_W{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CNT_W-1:0] k;
  logic             c_q;

  // Current digit step: shifted extraction keeps index widths uniform
  // for every legal DIGIT_W, including DIGIT_W == WIDTH.
  logic [31:0]      off;
  logic [DIGIT_W-1:0] a_sl;
  logic [DIGIT_W-1:0] b_sl;
  logic [DIGIT_W:0]   sum;
  logic [WIDTH-1:0]   result_next;

  always_comb begin
    off         = 32'(k) * 32'(DIGIT_W);
    a_sl        = DIGIT_W'(a_q >> off);
    b_sl        = DIGIT_W'(b_q >> off);
    sum         = {1'b0, a_sl} + {1'b0, b_sl} + (DIGIT_W + 1)'(c_q);
    // Replace only slice k of the result; other slices keep their bits.
    result_next = (result & ~(DMASK << off))
                | (WIDTH'(sum[DIGIT_W-1:0]) << off);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      k         <= '0;
      c_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= A;
            b_q      <= B;
            c_q      <= 1'b0;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          result <= result_next;
          c_q    <= sum[DIGIT_W];
          if (k == LAST) begin
            carry     <= sum[DIGIT_W];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          // result/carry hold here and keep their values back in IDLE.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_32bit_unsigned_seq.sv
// ---------------------------------------------------------------------------
// Bench for add_32bit_unsigned_seq: directed vector table on the default
// configuration, hand-written backpressure and mid-operation reset
// sequences, and a sweep over DIGIT_W = 1, 4, 8, 32 against a 33-bit golden
// sum and a subtraction cross-check.
// ---------------------------------------------------------------------------
module tb_add_32bit_unsigned_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main DUT (DIGIT_W = 8) ----------------
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry;

  add_32bit_unsigned_seq #(.WIDTH(32), .DIGIT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry)
  );

  // ---------------- sweep DUTs ----------------
  localparam int SW_DW [4] = '{1, 4, 8, 32};
  logic        sw_valid;
  logic        sw_out_ready;
  logic [31:0] sw_a;
  logic [31:0] sw_b;
  logic [3:0]  sw_ready;
  logic [3:0]  sw_ov;
  logic [3:0]  sw_c;
  logic [31:0] sw_res [4];

  add_32bit_unsigned_seq #(.WIDTH(32), .DIGIT_W(1)) sw0 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ready[0]),
    .A(sw_a), .B(sw_b), .out_valid(sw_ov[0]), .out_ready(sw_out_ready),
    .result(sw_res[0]), .carry(sw_c[0]));
  add_32bit_unsigned_seq #(.WIDTH(32), .DIGIT_W(4)) sw1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ready[1]),
    .A(sw_a), .B(sw_b), .out_valid(sw_ov[1]), .out_ready(sw_out_ready),
    .result(sw_res[1]), .carry(sw_c[1]));
  add_32bit_unsigned_seq #(.WIDTH(32), .DIGIT_W(8)) sw2 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ready[2]),
    .A(sw_a), .B(sw_b), .out_valid(sw_ov[2]), .out_ready(sw_out_ready),
    .result(sw_res[2]), .carry(sw_c[2]));
  add_32bit_unsigned_seq #(.WIDTH(32), .DIGIT_W(32)) sw3 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ready[3]),
    .A(sw_a), .B(sw_b), .out_valid(sw_ov[3]), .out_ready(sw_out_ready),
    .result(sw_res[3]), .carry(sw_c[3]));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Present an operand pair on the main DUT, wait for acceptance, then count
  // edges until out_valid rises (bounded). Leaves out_ready untouched.
  task automatic run_op(input logic [31:0] a_v, input logic [31:0] b_v,
                        output int lat);
    int w;
    a = a_v;
    b = b_v;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      step();
      w++;
    end
    check("accept_wait_bound", 64'(w < 100), 64'(1));
    step();
    in_valid = 1'b0;
    check("busy_in_ready", 64'(in_ready), 64'(0));
    check("busy_out_valid", 64'(out_valid), 64'(0));
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  // One operation on all four sweep DUTs at once.
  task automatic sweep_op(input logic [31:0] a_v, input logic [31:0] b_v);
    int          lat [4];
    logic [31:0] r   [4];
    logic        c   [4];
    logic [32:0] gold;
    logic [31:0] diff;
    for (int i = 0; i < 4; i++) begin
      lat[i] = -1;
      r[i]   = '0;
      c[i]   = 1'b0;
    end
    sw_a = a_v;
    sw_b = b_v;
    sw_valid = 1'b1;
    check("sweep_idle_ready", 64'(sw_ready), 64'(4'hF));
    step();
    sw_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (sw_ov[i] && lat[i] < 0) begin
          lat[i] = cyc;
          r[i]   = sw_res[i];
          c[i]   = sw_c[i];
        end
      end
    end
    gold = {1'b0, a_v} + {1'b0, b_v};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("dw%0d_latency", SW_DW[i]), 64'(lat[i]),
            64'(32 / SW_DW[i]));
      check($sformatf("dw%0d_sum a=%h b=%h", SW_DW[i], a_v, b_v),
            64'({c[i], r[i]}), 64'(gold));
      diff = r[i] - b_v;
      check($sformatf("dw%0d_sub_xcheck", SW_DW[i]), 64'(diff), 64'(a_v));
      check($sformatf("dw%0d_borrow_eq_carry", SW_DW[i]),
            64'(r[i] < b_v), 64'(c[i]));
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat;

    vecs[0] = '{a: 32'h0000_0001, b: 32'h0000_0002, res: 32'h0000_0003, c: 1'b0};
    vecs[1] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001, res: 32'h0000_0000, c: 1'b1};
    vecs[2] = '{a: 32'h8000_0000, b: 32'h8000_0000, res: 32'h0000_0000, c: 1'b1};
    vecs[3] = '{a: 32'h1234_5678, b: 32'h0FED_CBA8, res: 32'h2222_2220, c: 1'b0};
    vecs[4] = '{a: 32'hDEAD_BEEF, b: 32'h1000_0000, res: 32'hEEAD_BEEF, c: 1'b0};
    vecs[5] = '{a: 32'h0000_0000, b: 32'h0000_0000, res: 32'h0000_0000, c: 1'b0};
    vecs[6] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, res: 32'hFFFF_FFFE, c: 1'b1};

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    a            = '0;
    b            = '0;
    sw_valid     = 1'b0;
    sw_out_ready = 1'b1;
    sw_a         = '0;
    sw_b         = '0;

    // Reset state
    step();
    step();
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_carry", 64'(carry), 64'(0));
    rst_n = 1'b1;
    step();

    // Table-driven vectors with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(4));
      check($sformatf("vec%0d_result", i), 64'(result), 64'(vecs[i].res));
      check($sformatf("vec%0d_carry", i), 64'(carry), 64'(vecs[i].c));
      check($sformatf("vec%0d_done_in_ready", i), 64'(in_ready), 64'(0));
      step();
      check($sformatf("vec%0d_post_out_valid", i), 64'(out_valid), 64'(0));
      check($sformatf("vec%0d_post_in_ready", i), 64'(in_ready), 64'(1));
      check($sformatf("vec%0d_hold_in_idle", i), 64'(result), 64'(vecs[i].res));
    end

    // Backpressure: in_valid stays high with new operands the whole time
    out_ready = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h1000_0000;
    in_valid = 1'b1;
    step();
    a = 32'h1111_1111;
    b = 32'h2222_2222;
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    check("bp_latency", 64'(lat), 64'(4));
    for (int i = 0; i < 6; i++) begin
      check("bp_hold_result", 64'(result), 64'(32'hEEAD_BEEF));
      check("bp_hold_carry", 64'(carry), 64'(0));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
      step();
    end
    out_ready = 1'b1;
    step();
    check("bp_release_out_valid", 64'(out_valid), 64'(0));
    check("bp_release_in_ready", 64'(in_ready), 64'(1));
    check("bp_release_result", 64'(result), 64'(32'hEEAD_BEEF));
    step();
    in_valid = 1'b0;
    check("bp_second_accepted", 64'(in_ready), 64'(0));
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    check("bp2_latency", 64'(lat), 64'(4));
    check("bp2_result", 64'(result), 64'(32'h3333_3333));
    check("bp2_carry", 64'(carry), 64'(0));
    step();

    // Reset two cycles into BUSY
    a = 32'hAAAA_AAAA;
    b = 32'h5555_5555;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_result", 64'(result), 64'(0));
    check("midrst_carry", 64'(carry), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    step();
    rst_n = 1'b1;
    step();
    run_op(32'd5, 32'd7, lat);
    check("after_rst_latency", 64'(lat), 64'(4));
    check("after_rst_result", 64'(result), 64'(12));
    check("after_rst_carry", 64'(carry), 64'(0));
    step();

    // Parameter sweep
    sweep_op(32'h0000_0000, 32'h0000_0000);
    sweep_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int n = 0; n < 1000; n++) begin
      sweep_op($urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
